// File: rtl/seg7_scan_ctrl.sv
// Scan controller for an 8-digit common-anode 7-segment display.
// It blanks before each digit and double-buffers data so updates land on frame boundaries.
module seg7_scan_ctrl #(
  parameter int SLOT_CYC  = 100000,
  parameter int BLANK_CYC = 1000,
  parameter int CNT_W     = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic [7:0]  dp_in,
  input  logic [7:0]  en_in,
  input  logic        load,
  output logic        load_ack,
  output logic [7:0]  an,
  output logic [6:0]  a_to_g,
  output logic        dp,
  output logic        frame_tick
);

  typedef enum logic {BLANK, DRIVE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [31:0]      act_data, pend_data;
  logic [7:0]       act_dp, act_en, pend_dp, pend_en;
  logic             pend_valid;
  logic             slot_end, blank_end, wrap, commit;
  logic [3:0]       nibble;
  logic [6:0]       seg;

  assign slot_end  = (cnt == CNT_W'(SLOT_CYC - 1));
  assign blank_end = (cnt == CNT_W'(BLANK_CYC - 1));
  assign wrap      = slot_end && (idx == 3'd7);
  assign commit    = wrap && (pend_valid || load);
  assign nibble    = act_data[{idx, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .hex (nibble),
    .seg (seg)
  );

  // Outputs are loaded with next-cycle values so they line up with the state register.
  // A load on the wrap cycle itself bypasses the pending buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= BLANK;
      cnt        <= '0;
      idx        <= 3'd0;
      act_data   <= 32'd0;
      act_dp     <= 8'd0;
      act_en     <= 8'd0;
      pend_data  <= 32'd0;
      pend_dp    <= 8'd0;
      pend_en    <= 8'd0;
      pend_valid <= 1'b0;
      an         <= 8'hFF;
      a_to_g     <= 7'h7F;
      dp         <= 1'b1;
      load_ack   <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= wrap;
      load_ack   <= commit;
      if (load) begin
        pend_data  <= data_in;
        pend_dp    <= dp_in;
        pend_en    <= en_in;
        pend_valid <= 1'b1;
      end
      if (commit) begin
        act_data   <= load ? data_in : pend_data;
        act_dp     <= load ? dp_in   : pend_dp;
        act_en     <= load ? en_in   : pend_en;
        pend_valid <= 1'b0;
      end
      if (slot_end) begin
        cnt    <= '0;
        idx    <= idx + 3'd1;
        state  <= BLANK;
        an     <= 8'hFF;
        a_to_g <= 7'h7F;
        dp     <= 1'b1;
      end else begin
        cnt <= cnt + CNT_W'(1);
        if (state == DRIVE || blank_end) begin
          state  <= DRIVE;
          an     <= act_en[idx] ? ~(8'd1 << idx) : 8'hFF;
          a_to_g <= seg;
          dp     <= ~act_dp[idx];
        end else begin
          state  <= BLANK;
          an     <= 8'hFF;
          a_to_g <= 7'h7F;
          dp     <= 1'b1;
        end
      end
    end
  end

endmodule

// Hex nibble to active-low segments, bit6=a .. bit0=g.
module hex7seg (
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h7F;
    case (hex)
      4'h0: seg = 7'b0000001;
      4'h1: seg = 7'b1001111;
      4'h2: seg = 7'b0010010;
      4'h3: seg = 7'b0000110;
      4'h4: seg = 7'b1001100;
      4'h5: seg = 7'b0100100;
      4'h6: seg = 7'b0100000;
      4'h7: seg = 7'b0001111;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0000100;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b1100000;
      4'hC: seg = 7'b0110001;
      4'hD: seg = 7'b1000010;
      4'hE: seg = 7'b0110000;
      4'hF: seg = 7'b0111000;
      default: seg = 7'h7F;
    endcase
  end

endmodule
